// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// pipe_hazard_unit: tracks destination tags EX..WB and produces the ID stall, the EX bubble and the forwarded operands.
// Revision 1.0
module pipe_hazard_unit #(
  parameter int DATA_W      = 32,
  parameter int REG_BITS    = 5,
  parameter int STAGES      = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     id_valid,
  input  logic [REG_BITS-1:0]      id_rs_num,
  input  logic [REG_BITS-1:0]      id_rt_num,
  input  logic                     id_uses_rs,
  input  logic                     id_uses_rt,
  input  logic [REG_BITS-1:0]      id_rd_num,
  input  logic                     id_reg_write,
  input  logic                     id_is_load,
  input  logic                     branch_taken,
  input  logic                     cache_done,
  input  logic [STAGES*DATA_W-1:0] stage_data,
  input  logic [DATA_W-1:0]        rf_rs_data,
  input  logic [DATA_W-1:0]        rf_rt_data,
  output logic                     stall_id,
  output logic                     bubble_ex,
  output logic [DATA_W-1:0]        fwd_rs_data,
  output logic [DATA_W-1:0]        fwd_rt_data,
  output logic                     fwd_rs_hit,
  output logic                     fwd_rt_hit,
  output logic [STALL_CNT_W-1:0]   stall_count
);

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  logic [STAGES-1:0]      tag_valid;
  logic [STAGES-1:0]      tag_we;
  logic [STAGES-1:0]      tag_load;
  logic [REG_BITS-1:0]    tag_rd [STAGES];
  logic [STAGES-1:0]      match_rs;
  logic [STAGES-1:0]      match_rt;
  logic                   load_use;
  logic [STALL_CNT_W-1:0] stall_cnt;

  // Register 0 never matches, so writes to it are never forwarded.
  genvar gk;
  generate
    for (gk = 0; gk < STAGES; gk++) begin : g_match
      assign match_rs[gk] = tag_valid[gk] & tag_we[gk] &
                            (tag_rd[gk] == id_rs_num) & (id_rs_num != '0);
      assign match_rt[gk] = tag_valid[gk] & tag_we[gk] &
                            (tag_rd[gk] == id_rt_num) & (id_rt_num != '0);
    end
  endgenerate

  assign load_use  = id_valid & tag_load[0] &
                     ((id_uses_rs & match_rs[0]) | (id_uses_rt & match_rt[0]));
  assign stall_id  = ~cache_done | load_use;
  assign bubble_ex = cache_done & (load_use | branch_taken);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tag_valid <= '0;
      tag_we    <= '0;
      tag_load  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        tag_rd[k] <= '0;
      end
    end else if (cache_done) begin
      for (int k = 1; k < STAGES; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_we[k]    <= tag_we[k-1];
        tag_load[k]  <= tag_load[k-1];
        tag_rd[k]    <= tag_rd[k-1];
      end
      if (bubble_ex || !id_valid) begin
        tag_valid[0] <= 1'b0;
        tag_we[0]    <= 1'b0;
        tag_load[0]  <= 1'b0;
        tag_rd[0]    <= '0;
      end else begin
        tag_valid[0] <= 1'b1;
        tag_we[0]    <= id_reg_write;
        tag_load[0]  <= id_is_load;
        tag_rd[0]    <= id_rd_num;
      end
    end
  end

  // Scan oldest to youngest so the youngest matching stage wins; a load in EX has no data yet.
  always_comb begin
    fwd_rs_data = rf_rs_data;
    fwd_rs_hit  = 1'b0;
    fwd_rt_data = rf_rt_data;
    fwd_rt_hit  = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (match_rs[k] && !(k == 0 && tag_load[0])) begin
        fwd_rs_hit  = 1'b1;
        fwd_rs_data = stage_data[k*DATA_W +: DATA_W];
      end
      if (match_rt[k] && !(k == 0 && tag_load[0])) begin
        fwd_rt_hit  = 1'b1;
        fwd_rt_data = stage_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      stall_cnt <= '0;
    end else if (stall_id && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign stall_count = stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
`default_nettype none
// tb_pipe_hazard_unit: directed checks of tags, stalls, bubbles, forwarding and stall counter.
module tb_pipe_hazard_unit;

  localparam logic [31:0] D0 = 32'hAAAA_0000;
  localparam logic [31:0] D1 = 32'hBBBB_1111;
  localparam logic [31:0] D2 = 32'hCCCC_2222;
  localparam logic [31:0] RS = 32'h1111_1111;
  localparam logic [31:0] RT = 32'h2222_2222;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_is_load;
  logic [4:0]  id_rs_num, id_rt_num, id_rd_num;
  logic        branch_taken, cache_done, cache_done_s;
  logic [95:0] stage_data;
  logic [31:0] rf_rs_data, rf_rt_data;

  logic        stall_id, bubble_ex, fwd_rs_hit, fwd_rt_hit;
  logic [31:0] fwd_rs_data, fwd_rt_data;
  logic [15:0] stall_count;

  logic        s_stall_id, s_bubble_ex, s_fwd_rs_hit, s_fwd_rt_hit;
  logic [31:0] s_fwd_rs_data, s_fwd_rt_data;
  logic [3:0]  s_stall_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.DATA_W(32), .REG_BITS(5), .STAGES(3), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst_b(rst_b), .id_valid(id_valid), .id_rs_num(id_rs_num),
    .id_rt_num(id_rt_num), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rd_num(id_rd_num), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .branch_taken(branch_taken), .cache_done(cache_done), .stage_data(stage_data),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .stall_id(stall_id),
    .bubble_ex(bubble_ex), .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data),
    .fwd_rs_hit(fwd_rs_hit), .fwd_rt_hit(fwd_rt_hit), .stall_count(stall_count)
  );

  pipe_hazard_unit #(.DATA_W(32), .REG_BITS(5), .STAGES(3), .STALL_CNT_W(4)) dut_sat (
    .clk(clk), .rst_b(rst_b), .id_valid(id_valid), .id_rs_num(id_rs_num),
    .id_rt_num(id_rt_num), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rd_num(id_rd_num), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .branch_taken(branch_taken), .cache_done(cache_done_s), .stage_data(stage_data),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .stall_id(s_stall_id),
    .bubble_ex(s_bubble_ex), .fwd_rs_data(s_fwd_rs_data), .fwd_rt_data(s_fwd_rt_data),
    .fwd_rs_hit(s_fwd_rs_hit), .fwd_rt_hit(s_fwd_rt_hit), .stall_count(s_stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt,
                        input logic [4:0] rd, input logic we, input logic ld);
    id_valid = v; id_rs_num = rs; id_uses_rs = urs; id_rt_num = rt; id_uses_rt = urt;
    id_rd_num = rd; id_reg_write = we; id_is_load = ld;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_b = 1'b0; cache_done = 1'b1; cache_done_s = 1'b1; branch_taken = 1'b0;
    stage_data = {D2, D1, D0}; rf_rs_data = RS; rf_rt_data = RT;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    rst_b = 1'b1;
    #1;
    chk("rst_stall", {31'd0, stall_id}, 32'd0);
    chk("rst_bubble", {31'd0, bubble_ex}, 32'd0);
    chk("rst_rs_hit", {31'd0, fwd_rs_hit}, 32'd0);
    chk("rst_rs_data", fwd_rs_data, RS);
    chk("rst_rt_data", fwd_rt_data, RT);
    chk("rst_count", {16'd0, stall_count}, 32'd0);

    // add r3
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();
    // add r6 <- r3, r4
    set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0);
    chk("alu_rs_hit", {31'd0, fwd_rs_hit}, 32'd1);
    chk("alu_rs_data", fwd_rs_data, D0);
    chk("alu_rt_hit", {31'd0, fwd_rt_hit}, 32'd0);
    chk("alu_rt_data", fwd_rt_data, RT);
    chk("alu_stall", {31'd0, stall_id}, 32'd0);
    tick();
    // lw r5, reads r3 (now in stage 1)
    set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    chk("s1_rs_data", fwd_rs_data, D1);
    tick();
    // add r7 <- r3, r5 : load-use on r5
    set_id(1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0);
    chk("lu_stall", {31'd0, stall_id}, 32'd1);
    chk("lu_bubble", {31'd0, bubble_ex}, 32'd1);
    chk("lu_rt_hit", {31'd0, fwd_rt_hit}, 32'd0);
    chk("lu_rs_data", fwd_rs_data, D2);
    tick();
    chk("lu2_stall", {31'd0, stall_id}, 32'd0);
    chk("lu2_bubble", {31'd0, bubble_ex}, 32'd0);
    chk("lu2_rt_hit", {31'd0, fwd_rt_hit}, 32'd1);
    chk("lu2_rt_data", fwd_rt_data, D1);
    chk("lu2_rs_hit", {31'd0, fwd_rs_hit}, 32'd0);
    chk("lu2_count", {16'd0, stall_count}, 32'd1);
    tick();
    // add r0
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
    chk("r0_rs_hit", {31'd0, fwd_rs_hit}, 32'd0);
    chk("r0_rs_data", fwd_rs_data, RS);
    chk("r0_rt_data", fwd_rt_data, D1);

    // cache miss for 5 cycles with a branch pending
    set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    cache_done = 1'b0; branch_taken = 1'b1;
    #1;
    chk("miss_stall", {31'd0, stall_id}, 32'd1);
    chk("miss_bubble", {31'd0, bubble_ex}, 32'd0);
    repeat (5) tick();
    chk("miss_frozen", fwd_rs_data, D1);
    chk("miss_count", {16'd0, stall_count}, 32'd6);
    cache_done = 1'b1;
    #1;
    chk("br_bubble", {31'd0, bubble_ex}, 32'd1);
    chk("br_stall", {31'd0, stall_id}, 32'd0);
    tick();
    branch_taken = 1'b0;
    set_id(1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd8, 1'b1, 1'b0);
    chk("br_rs_data", fwd_rs_data, D2);
    chk("unused_rt_hit", {31'd0, fwd_rt_hit}, 32'd1);
    chk("unused_rt_data", fwd_rt_data, D2);
    chk("br_count", {16'd0, stall_count}, 32'd6);

    // three valid tags then an asynchronous reset between edges
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);  tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0); tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0); tick();
    set_id(1'b0, 5'd9, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0);
    chk("pre_rst_rs", fwd_rs_data, D2);
    chk("pre_rst_rt", fwd_rt_data, D1);
    rst_b = 1'b0;
    #1;
    chk("arst_rs_hit", {31'd0, fwd_rs_hit}, 32'd0);
    chk("arst_rt_hit", {31'd0, fwd_rt_hit}, 32'd0);
    chk("arst_rs_data", fwd_rs_data, RS);
    chk("arst_count", {16'd0, stall_count}, 32'd0);
    rst_b = 1'b1;
    tick();
    chk("post_rst_rs_hit", {31'd0, fwd_rs_hit}, 32'd0);

    // saturation of the 4-bit counter
    rst_b = 1'b0; #1; rst_b = 1'b1;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    cache_done_s = 1'b0;
    #1;
    chk("sat_stall", {31'd0, s_stall_id}, 32'd1);
    repeat (10) tick();
    chk("sat_count10", {28'd0, s_stall_count}, 32'd10);
    repeat (10) tick();
    chk("sat_count20", {28'd0, s_stall_count}, 32'd15);
    repeat (3) tick();
    chk("sat_hold", {28'd0, s_stall_count}, 32'd15);
    cache_done_s = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
